// File: rtl/decodificador_excesso_3.sv
// decodificador_excesso_3
//   Receive-side excess-3 decoder. It accepts one excess-3 digit per
//   in_valid/in_ready handshake and converts it to BCD 8421 (code - 3).
//   DIGITS decoded digits are packed into one BCD word, with the first
//   received digit in the most significant nibble. The word is then offered
//   on an out_valid/out_ready port. erro flags any non-excess-3 code that
//   arrived in that word.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_digit   excess-3 digit (WIDTH bits)
//   in_valid   in_digit is valid this cycle
//   in_ready   decoder can accept a digit (low while rst=1 and while a word waits)
//   bcd_out    packed BCD word (WIDTH*DIGITS bits); holds the last word until the next one completes
//   out_valid  bcd_out/erro hold a complete word
//   out_ready  consumer takes the word
//   erro       at least one invalid code in the current word; qualified by out_valid

module decodificador_excesso_3 #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_digit,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH*DIGITS-1:0]   bcd_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      erro
);

    localparam int WW = WIDTH * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic {
        COLETA,
        SAIDA
    } estado_t;

    estado_t           estado, prox_estado;
    logic [CW-1:0]     cont;
    logic [WW-1:0]     shift;
    logic              acc_erro;

    logic              aceita;
    logic              ultimo;
    logic [WIDTH-1:0]  dec_nibble;
    logic              dec_erro;
    logic [WW-1:0]     shift_nxt;

    // Bit WIDTH is the invalid-code flag. The low nibble is the BCD value,
    // forced to 0 for invalid codes. Valid codes are 3..12, so the
    // subtraction never borrows.
    function automatic logic [WIDTH:0] decodifica(input logic [WIDTH-1:0] c);
        logic [WIDTH:0] r;
        if (c >= WIDTH'(3) && c <= WIDTH'(12))
            r = {1'b0, c - WIDTH'(3)};
        else
            r = {1'b1, {WIDTH{1'b0}}};
        return r;
    endfunction

    always_comb begin
        {dec_erro, dec_nibble} = decodifica(in_digit);
    end

    assign in_ready  = (estado == COLETA) && !rst;
    assign out_valid = (estado == SAIDA);
    assign aceita    = in_valid && in_ready;
    assign ultimo    = aceita && (cont == CW'(DIGITS - 1));

    // The shift form is used instead of a slice so that DIGITS=1 needs no
    // special case. The oldest nibble drops off the top.
    assign shift_nxt = (shift << WIDTH) | WW'(dec_nibble);

    // Next-state logic
    always_comb begin
        prox_estado = estado;
        case (estado)
            COLETA:  if (ultimo)    prox_estado = SAIDA;
            SAIDA:   if (out_ready) prox_estado = COLETA;
            default: prox_estado = COLETA;
        endcase
    end

    // State, collection and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            estado   <= COLETA;
            cont     <= '0;
            shift    <= '0;
            acc_erro <= 1'b0;
            bcd_out  <= '0;
            erro     <= 1'b0;
        end else begin
            estado <= prox_estado;
            if (aceita) begin
                shift <= shift_nxt;
                if (ultimo) begin
                    bcd_out  <= shift_nxt;
                    erro     <= acc_erro | dec_erro;
                    cont     <= '0;
                    acc_erro <= 1'b0;
                end else begin
                    cont     <= cont + CW'(1);
                    acc_erro <= acc_erro | dec_erro;
                end
            end
            // erro drops together with out_valid. bcd_out is kept.
            if (out_valid && out_ready)
                erro <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decodificador_excesso_3.sv
// tb_decodificador_excesso_3
//   Directed bench for decodificador_excesso_3 (DIGITS=4). Inputs are driven
//   1 time unit after each rising edge, and outputs are sampled at that same
//   point. Expected words are hand-computed from the excess-3 table.

module tb_decodificador_excesso_3;

    logic        clk;
    logic        rst;
    logic [3:0]  in_digit;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd_out;
    logic        out_valid;
    logic        out_ready;
    logic        erro;

    int checks   = 0;
    int failures = 0;

    decodificador_excesso_3 #(
        .DIGITS (4),
        .WIDTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_digit  (in_digit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .erro      (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends four codes on consecutive cycles (MS nibble first) and checks the
    // completed word. When out_ready=1, it also checks that the word is shown
    // for exactly one cycle.
    task automatic send_word(input string tag, input logic [15:0] codes,
                             input logic [15:0] exp_bcd, input logic exp_err);
        for (int i = 0; i < 4; i++) begin
            in_digit = codes[15-4*i -: 4];
            in_valid = 1'b1;
            tick();
            if (i < 3) chk({tag, "_partial_ov"}, 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        chk({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        chk({tag, "_erro"}, 32'(erro), 32'(exp_err));
        chk({tag, "_ov"}, 32'(out_valid), 32'd1);
        chk({tag, "_ir"}, 32'(in_ready), 32'd0);
        if (out_ready) begin
            tick();
            chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
            chk({tag, "_ir_back"}, 32'(in_ready), 32'd1);
            chk({tag, "_erro_drop"}, 32'(erro), 32'd0);
            chk({tag, "_bcd_held"}, 32'(bcd_out), 32'(exp_bcd));
        end
    endtask

    initial begin
        // 1. Reset with a digit presented
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_digit  = 4'b0101;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_bcd", 32'(bcd_out), 32'd0);
            chk("rst_ov", 32'(out_valid), 32'd0);
            chk("rst_erro", 32'(erro), 32'd0);
            chk("rst_ir", 32'(in_ready), 32'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rel_ir", 32'(in_ready), 32'd1);
        tick();
        chk("rel_ov", 32'(out_valid), 32'd0);

        // 2. Nominal word (a digit counted in reset would misalign this)
        send_word("nom", 16'h4567, 16'h1234, 1'b0);

        // 3. Code bounds 0011 and 1100
        send_word("bounds", 16'h3CC3, 16'h0990, 1'b0);

        // 4. Invalid codes, then a clean word clears erro
        send_word("inval", 16'h406F, 16'h1030, 1'b1);
        send_word("clean", 16'h8888, 16'h5555, 1'b0);

        // 5. Gaps between digits, then backpressure
        out_ready = 1'b0;
        in_digit = 4'b1000; in_valid = 1'b1; tick();
        in_valid = 1'b0; in_digit = 4'b1111; tick(); tick(); tick();
        in_digit = 4'b1001; in_valid = 1'b1; tick();
        in_valid = 1'b0; tick(); tick();
        in_digit = 4'b1010; in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        chk("gap_ov_partial", 32'(out_valid), 32'd0);
        chk("gap_ir_partial", 32'(in_ready), 32'd1);
        in_digit = 4'b1011; in_valid = 1'b1; tick();
        chk("gap_bcd", 32'(bcd_out), 32'h5678);
        chk("gap_ov", 32'(out_valid), 32'd1);
        in_digit = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_bcd", 32'(bcd_out), 32'h5678);
            chk("bp_erro", 32'(erro), 32'd0);
            chk("bp_ov", 32'(out_valid), 32'd1);
            chk("bp_ir", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("hs_ov", 32'(out_valid), 32'd0);
        chk("hs_ir", 32'(in_ready), 32'd1);
        tick();  // 1001 accepted as the first digit
        in_digit = 4'b1010; tick();
        in_digit = 4'b1011; tick();
        in_digit = 4'b1100; tick();
        in_valid = 1'b0;
        chk("after_bp_bcd", 32'(bcd_out), 32'h6789);
        chk("after_bp_ov", 32'(out_valid), 32'd1);
        tick();

        // 6. Reset mid-word
        in_digit = 4'b0100; in_valid = 1'b1; tick();
        in_digit = 4'b0101; tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_bcd", 32'(bcd_out), 32'd0);
        chk("mid_rst_ov", 32'(out_valid), 32'd0);
        send_word("fresh", 16'hBA98, 16'h8765, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
